// File: rtl/apb3_fabric_pkg.sv
// rtl/apb3_fabric_pkg.sv - shared types and constants for the APB3 slot decoder
package apb3_fabric_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ERR    = 2'd2
  } state_e;

  localparam int          SLOT_W    = 4;
  localparam int          MAX_SLOTS = 16;
  localparam logic [31:0] ERR_RDATA = 32'h0;

endpackage

// File: rtl/apb3_slot_decoder_if.sv
// rtl/apb3_slot_decoder_if.sv - bridge-side and slave-side APB3 signals of the slot decoder
interface apb3_slot_decoder_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_SLOTS  = 4
);

  logic                    PSEL;
  logic                    PENABLE;
  logic                    PWRITE;
  logic [ADDR_WIDTH-1:0]   PADDR;
  logic [31:0]             PRDATA;
  logic                    PREADY;
  logic                    PSLVERR;
  logic [NUM_SLOTS-1:0]    PSELS;
  logic [NUM_SLOTS-1:0]    PREADYS;
  logic [NUM_SLOTS-1:0]    PSLVERRS;
  logic [32*NUM_SLOTS-1:0] PRDATAS;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR,
    input  PRDATA, PREADY, PSLVERR,
    input  PSELS,
    output PREADYS, PSLVERRS, PRDATAS
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR,
    output PRDATA, PREADY, PSLVERR,
    output PSELS,
    input  PREADYS, PSLVERRS, PRDATAS
  );

endinterface

// File: rtl/apb3_wait_timer.sv
// rtl/apb3_wait_timer.sv - saturating wait-state counter with expiry flag
module apb3_wait_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int            CW    = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && (r_count != LIMIT)) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign o_expired = (r_count == LIMIT);

endmodule

// File: rtl/apb3_slot_decoder.sv
// rtl/apb3_slot_decoder.sv - APB3 slot decoder with per-transfer wait-state watchdog
module apb3_slot_decoder
  import apb3_fabric_pkg::*;
#(
  parameter int NUM_SLOTS = 4,
  parameter int SLOT_LSB  = 8,
  parameter int TIMEOUT   = 255
) (
  input  logic              HCLK,
  input  logic              HRESETN,
  apb3_slot_decoder_if.slave bus,
  output logic              TOUT_FLAG,
  output logic [SLOT_W-1:0] TOUT_SLOT,
  input  logic              TOUT_CLR
);

  state_e            r_state;
  logic [SLOT_W-1:0] r_slot;

  logic [SLOT_W-1:0]    w_idx;
  logic                 w_setup;
  logic                 w_mapped;
  logic                 w_rdy;
  logic                 w_expired;
  logic                 w_timeout;
  logic                 w_cnt_en;
  logic                 w_accept;
  logic [MAX_SLOTS-1:0] w_rdy_vec;
  logic [MAX_SLOTS-1:0] w_err_vec;
  logic [31:0]          w_rd_arr [MAX_SLOTS];
  logic                 w_unused;

  assign w_idx    = bus.PADDR[SLOT_LSB +: SLOT_W];
  assign w_setup  = bus.PSEL && !bus.PENABLE;
  assign w_mapped = ({1'b0, r_slot} < 5'(NUM_SLOTS));
  assign w_unused = &{1'b0, bus.PWRITE, bus.PADDR};

  // Unpopulated slots read as never-ready, no-error, zero data.
  for (genvar g = 0; g < MAX_SLOTS; g++) begin : g_slot
    if (g < NUM_SLOTS) begin : g_pop
      assign w_rdy_vec[g] = bus.PREADYS[g];
      assign w_err_vec[g] = bus.PSLVERRS[g];
      assign w_rd_arr[g]  = bus.PRDATAS[32*g +: 32];
      assign bus.PSELS[g] = HRESETN && bus.PSEL && (w_idx == SLOT_W'(g))
                            && !((r_state == ST_ERR) && (r_slot == SLOT_W'(g)));
    end else begin : g_unpop
      assign w_rdy_vec[g] = 1'b0;
      assign w_err_vec[g] = 1'b0;
      assign w_rd_arr[g]  = ERR_RDATA;
    end
  end

  assign w_rdy     = w_rdy_vec[r_slot];
  assign w_timeout = (r_state == ST_ACCESS) && w_mapped && !w_rdy && w_expired;
  assign w_cnt_en  = (r_state == ST_ACCESS) && w_mapped && !w_rdy && !w_expired;
  assign w_accept  = (r_state != ST_ACCESS) && w_setup;

  apb3_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .i_clk     (HCLK),
    .i_rstn    (HRESETN),
    .i_clr     (w_accept),
    .i_en      (w_cnt_en),
    .o_expired (w_expired)
  );

  always_ff @(posedge HCLK) begin
    if (!HRESETN) begin
      r_state <= ST_IDLE;
      r_slot  <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_ERR: begin
          if (w_setup) begin
            r_state <= ST_ACCESS;
            r_slot  <= w_idx;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_ACCESS: begin
          if (w_timeout) begin
            r_state <= ST_ERR;
          end else if (!w_mapped || w_rdy) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETN) begin
      TOUT_FLAG <= 1'b0;
      TOUT_SLOT <= '0;
    end else if (w_timeout) begin
      TOUT_FLAG <= 1'b1;
      TOUT_SLOT <= r_slot;
    end else if (TOUT_CLR) begin
      TOUT_FLAG <= 1'b0;
    end
  end

  always_comb begin
    bus.PREADY  = 1'b0;
    bus.PSLVERR = 1'b0;
    bus.PRDATA  = ERR_RDATA;
    if (HRESETN) begin
      case (r_state)
        ST_IDLE: begin
          if (bus.PENABLE) begin
            bus.PREADY  = 1'b1;
            bus.PSLVERR = 1'b1;
          end
        end
        ST_ACCESS: begin
          if (!w_mapped || w_timeout) begin
            bus.PREADY  = 1'b1;
            bus.PSLVERR = 1'b1;
          end else if (w_rdy) begin
            bus.PREADY  = 1'b1;
            bus.PSLVERR = w_err_vec[r_slot];
            bus.PRDATA  = w_rd_arr[r_slot];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/apb3_slot_decoder.md
# apb3_slot_decoder

APB3 fabric stage that sits directly downstream of the AHB-to-APB3 bridge. It decodes the bridge's single APB3 master port into up to 16 peripheral slots and returns the selected slot's PREADY, PSLVERR and PRDATA to the bridge. A per-transfer wait-state watchdog forces an error completion when a slave stalls, so a hung peripheral cannot lock the AHB bus. Transfers to an unmapped slot also complete with an error.

## Interface
- NUM_SLOTS, 4: populated slots, 1..16; slot indices >= NUM_SLOTS are unmapped.
- SLOT_LSB, 8: PADDR[SLOT_LSB+3:SLOT_LSB] is the slot index.
- ADDR_WIDTH, 32: PADDR width; must be >= SLOT_LSB+4.
- TIMEOUT, 255: maximum wait states allowed per transfer, 1..65535.

- HCLK  in  1  sole clock, rising edge.
- HRESETN  in  1  synchronous, active-low reset.
- PSEL  in  1  master select from bridge.
- PENABLE  in  1  master access phase.
- PWRITE  in  1  master direction; passed through, not used internally.
- PADDR  in  ADDR_WIDTH  master address.
- PRDATA  out  32  read data to bridge.
- PREADY  out  1  transfer complete to bridge.
- PSLVERR  out  1  error response to bridge.
- PSELS  out  NUM_SLOTS  one-hot slave selects.
- PREADYS  in  NUM_SLOTS  per-slave ready.
- PSLVERRS  in  NUM_SLOTS  per-slave error.
- PRDATAS  in  32*NUM_SLOTS  per-slave read data; slot n is bits [32n+31:32n].
- TOUT_FLAG  out  1  sticky, set by any watchdog completion.
- TOUT_SLOT  out  4  slot index of the most recent timeout.
- TOUT_CLR  in  1  clears TOUT_FLAG; set wins over clear in the same cycle.

## Operation
- States: IDLE, ACCESS, ERR.
- PSELS[n] = PSEL && (PADDR slot index == n) && HRESETN. It is combinational, so it is valid in the SETUP cycle.
- IDLE:
  - PSEL=1 and PENABLE=0 (SETUP): latch the slot index into slot_q, clear the wait counter, go to ACCESS.
  - PENABLE=1 with no preceding SETUP (protocol violation): drive PREADY=1, PSLVERR=1, PRDATA=0 that cycle; stay in IDLE.
- ACCESS with slot_q mapped: PREADY, PSLVERR and PRDATA are muxed from slot_q.
  - PREADYS[slot_q]=1: the transfer completes and the state goes to IDLE.
  - PREADYS[slot_q]=0 and counter < TIMEOUT: counter increments and the state stays in ACCESS.
  - PREADYS[slot_q]=0 and counter == TIMEOUT: drive PREADY=1, PSLVERR=1, PRDATA=0; set TOUT_FLAG; load TOUT_SLOT=slot_q; go to ERR.
- ACCESS with slot_q unmapped: drive PREADY=1, PSLVERR=1, PRDATA=0 on the first access cycle and go to IDLE. No PSELS bit is asserted for the transfer.
- ERR: forces PSELS[slot_q]=0 for one cycle so the abandoned slave sees its transfer terminated, then goes to IDLE.
  - A SETUP arriving during ERR is accepted: latch the slot, go to ACCESS.
  - If the new SETUP targets the same slot, that slot is still held off during the ERR cycle.
- Outside ACCESS (and outside the IDLE protocol-violation response): PREADY=0, PSLVERR=0, PRDATA=0.
- Counter width is $clog2(TIMEOUT+1). It saturates and never wraps.

## Timing
- Reset values: state IDLE, slot_q=0, counter=0, TOUT_FLAG=0, TOUT_SLOT=0. While HRESETN=0: PREADY, PSLVERR, PRDATA and PSELS are all 0.
- Reset asserted mid-transfer: takes effect at the next HCLK edge. No completion is generated for the aborted transfer.
- Zero-wait slave: SETUP at cycle 0, ACCESS at cycle 1 with PREADY=1. Completion adds no latency beyond APB3.
- Watchdog: the slave is allowed exactly TIMEOUT wait cycles. The forced completion appears in access cycle TIMEOUT+1.
- Slave PREADYS=1 in the same cycle the counter reaches TIMEOUT: treated as a normal completion. No timeout is flagged.
- PREADY, PSLVERR and PRDATA are combinational from registered state and slave inputs. There is no added pipeline register.

## Structure
- Package apb3_fabric_pkg holds:
  - the state enum (IDLE, ACCESS, ERR);
  - SLOT_W = 4;
  - the constants ERR_RDATA = 32'h0 and MAX_SLOTS = 16.
- Sub-module apb3_wait_timer: a saturating wait-state counter with clear, enable and expired (counter == TIMEOUT) outputs, parameterised by TIMEOUT. The decoder instantiates it once.
- Everything else is flat in apb3_slot_decoder.

## Test plan
- Read from slot 2 at PADDR=32'h0000_0200, where the slave asserts PREADYS=1 immediately and returns PRDATAS=32'hCAFE_F00D:
  - PSELS=4'b0100 in SETUP and ACCESS;
  - PRDATA=32'hCAFE_F00D with PREADY=1 and PSLVERR=0 in cycle 1.
- Write to slot 1 with 3 wait states: PREADY=1 in access cycle 4, PSLVERR follows PSLVERRS[1], and TOUT_FLAG stays 0.
- Slot 3 never ready, TIMEOUT=4:
  - PREADY=1, PSLVERR=1, PRDATA=0 in access cycle 5;
  - TOUT_FLAG=1 and TOUT_SLOT=3 afterwards;
  - PSELS[3]=0 in the following cycle.
- Access at PADDR=32'h0000_0500 with NUM_SLOTS=4:
  - PSELS=0 throughout;
  - PREADY=1 and PSLVERR=1 in the first access cycle.
- Assert HRESETN=0 during a stalled slot 0 access: all outputs read 0 after the next edge, and the next SETUP decodes normally.
- Corner cases:
  - PENABLE=1 from IDLE gives a one-cycle PREADY=1, PSLVERR=1 response;
  - TOUT_CLR=1 in the same cycle as a new timeout leaves TOUT_FLAG=1.
